neuron_mac_sequencer: RTL and testbench
=======================================

// Module: neuron_mac_sequencer
// PURPOSE
//  Sequences one perceptron evaluation over a registered weight ROM and an input-vector buffer.
//  Walks weight addresses 1..N_INPUTS and input indices 0..N_INPUTS-1 in lockstep.
//  Accumulates the signed products, adds BIAS and compares the sum against THRESH.
//  Sits between the layer controller (start/done) and one neuron ROM plus its shared input buffer.
// PARAMETERS
//  N_INPUTS  10  number of weights/inputs per evaluation (>=1)
//  DATA_W    16  weight and input width, signed two's complement
//  ADDR_W    16  ROM address width; x_addr uses the same width
//  ACC_W     40  accumulator width; must be >= 2*DATA_W + clog2(N_INPUTS+1)
//  BIAS      0   signed constant preloaded into the accumulator on start
//  THRESH    0   signed firing threshold, compared against the final accumulator
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       asynchronous, active-high reset
//  start     in   1       request an evaluation; sampled only in IDLE
//  busy      out  1       high from the cycle after start is accepted until done
//  done      out  1       one-cycle pulse; acc_out and fire are valid from this cycle
//  rom_addr  out  ADDR_W  weight ROM address; ROM has 1-cycle registered read latency
//  rom_dout  in   DATA_W  weight returned by the ROM
//  x_addr    out  ADDR_W  input buffer index; buffer has the same 1-cycle registered latency
//  x_data    in   DATA_W  input value returned by the buffer
//  acc_out   out  ACC_W   final signed sum; held until the next start is accepted
//  fire      out  1       acc_out >= THRESH (signed); held with acc_out
// BEHAVIOUR
//  Reset: state=IDLE; busy, done and fire = 0; acc_out = 0; rom_addr = 0; x_addr = 0.
//  FSM states and transitions:
//   - IDLE  --start-->       ISSUE (at this edge the accumulator loads BIAS)
//   - ISSUE --addr issued N-->  DRAIN
//   - DRAIN --last accumulate--> DONE
//   - DONE  --always-->      IDLE
//  Timing, with edge 0 = the edge that accepts start:
//   - ISSUE drives rom_addr = k and x_addr = k-1 during cycle k, for k = 1..N_INPUTS.
//   - The pipeline is: address -> ROM/buffer register -> product register (2*DATA_W, signed) -> accumulate.
//   - The product for index k is added at edge k+2. acc_out and fire are registered at edge N_INPUTS+2.
//   - done is high during cycle N_INPUTS+3. Total latency is N_INPUTS+3 cycles (13 at the default).
//  Outside ISSUE, rom_addr and x_addr return to 0. Address 0 is never accumulated.
//  Arithmetic: products are sign-extended to ACC_W. There is no saturation; wrap-around is
//   excluded by the ACC_W rule. Internal running sum is separate; acc_out only updates at completion.
//  start while busy, or in DONE, is ignored; no queuing.
//   start in the IDLE cycle right after DONE is accepted normally (back-to-back evaluations).
//  Reset mid-operation: abandon immediately, all outputs go to reset values, no done pulse.
//  acc_out and fire stay stable from done until the edge after the next start is accepted.
// STRUCTURE
//  Package neuron_pkg:
//   - state enum {IDLE, ISSUE, DRAIN, DONE}
//   - DATA_W, ADDR_W and ACC_W defaults
//   - function clog2
//  Sub-module neuron_mac: product register plus accumulator, with clear/load-bias, enable and
//   signed sign-extension. The sequencer owns the FSM, the address counter and the
//   valid shift register (2 stages) that gates the accumulate enable.
// TESTING
//  The bench models the ROM and input buffer as 1-cycle registered memories.
//  Default ROM weights at addr 1..10: 0,0,4,5,6,8,0,0,0,0.
//  1. x all = 1, start one cycle -> done at cycle 13; acc_out = 23; fire = 1; busy high cycles 1..12.
//  2. x[i] = i+1 -> acc_out = 110, fire = 1. Then x all = -1 -> acc_out = -23, fire = 0 (THRESH = 0).
//  3. start held high through the run and pulsed at cycle 5 -> exactly one done; rom_addr sequence 1..10 once.
//  4. start asserted the cycle after done -> second done 13 cycles later.
//     First acc_out is held until the second start's next edge.
//  5. rst asserted at cycle 6 of a run -> all outputs are 0 while rst is high; no done pulse.
//     A subsequent run gives the correct result.
//  6. BIAS = -30, x all = 1 -> acc_out = -7, fire = 0.
//     THRESH = -7 with the same stimulus -> fire = 1 (equality fires).

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the perceptron MAC sequencer.
//  - state_t    : sequencer FSM states
//  - *_DEF      : default widths used by the sequencer and its MAC datapath
//  - clog2      : ceiling log2, used for accumulator width sanity checks
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int ACC_W_DEF  = 40;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// Product register plus accumulator for one neuron.
//  clk, rst   : clock, asynchronous active-high reset
//  load_bias  : preload the accumulator with BIAS (start of an evaluation)
//  acc_en     : add the registered product into the accumulator
//  weight     : signed weight from the ROM register
//  sample     : signed input from the buffer register
//  sum        : accumulator plus the current sign-extended product, i.e. the
//               value the accumulator takes on an enabled edge
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int BIAS   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_bias,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] sample,
    output logic [ACC_W-1:0]  sum
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] weight_ext;
    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] prod_reg;
    logic        [ACC_W-1:0]  prod_ext;
    logic        [ACC_W-1:0]  acc_reg;

    // Operands are widened first so the multiply is evaluated at full product width.
    assign weight_ext = {{DATA_W{weight[DATA_W-1]}}, weight};
    assign sample_ext = {{DATA_W{sample[DATA_W-1]}}, sample};
    assign prod_ext   = {{(ACC_W-PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
    assign sum        = acc_reg + prod_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_reg <= '0;
            acc_reg  <= '0;
        end else begin
            prod_reg <= weight_ext * sample_ext;
            if (load_bias) begin
                acc_reg <= ACC_W'(BIAS);
            end else if (acc_en) begin
                acc_reg <= sum;
            end
        end
    end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Sequences one perceptron evaluation: walks ROM addresses 1..N_INPUTS and
// input indices 0..N_INPUTS-1 in lockstep, accumulates signed products on
// top of BIAS and compares the final sum against THRESH.
//  clk, rst          : clock, asynchronous active-high reset
//  start             : evaluation request, only honoured in IDLE
//  busy              : evaluation in progress (ISSUE or DRAIN)
//  done              : one-cycle completion pulse
//  rom_addr/rom_dout : weight ROM, 1-cycle registered read
//  x_addr/x_data     : input buffer, 1-cycle registered read
//  acc_out, fire     : final sum and threshold decision, held between runs
module neuron_mac_sequencer
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 10,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int BIAS     = 0,
    parameter int THRESH   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_data,
    output logic [ACC_W-1:0]  acc_out,
    output logic              fire
);

    localparam int MIN_ACC_W = 2 * DATA_W + clog2(N_INPUTS + 1);

    generate
        if (ACC_W < MIN_ACC_W) begin : g_acc_w_too_small
            $error("neuron_mac_sequencer: ACC_W too small for N_INPUTS products");
        end
    endgenerate

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic [ADDR_W-1:0] x_addr_reg;
    logic [1:0]        vld_reg;   // product pipeline valid: [0] ROM data, [1] product
    logic [1:0]        last_reg;  // marks the final index travelling down the pipe
    logic [ACC_W-1:0]  acc_out_reg;
    logic              fire_reg;
    logic [ACC_W-1:0]  mac_sum;
    logic              accept;
    logic              last_addr;

    assign accept    = (state_reg == IDLE) && start;
    assign last_addr = (rom_addr_reg == ADDR_W'(N_INPUTS));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)       state_next = ISSUE;
            ISSUE:   if (last_addr)   state_next = DRAIN;
            DRAIN:   if (last_reg[1]) state_next = DONE;
            DONE:                     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign done = (state_reg == DONE);

    // Address counter: rom_addr doubles as the issue counter; x_addr trails by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_reg <= '0;
            x_addr_reg   <= '0;
        end else if (accept) begin
            rom_addr_reg <= ADDR_W'(1);
            x_addr_reg   <= '0;
        end else if ((state_reg == ISSUE) && !last_addr) begin
            rom_addr_reg <= rom_addr_reg + ADDR_W'(1);
            x_addr_reg   <= x_addr_reg + ADDR_W'(1);
        end else begin
            rom_addr_reg <= '0;
            x_addr_reg   <= '0;
        end
    end

    assign rom_addr = rom_addr_reg;
    assign x_addr   = x_addr_reg;

    // Two-stage valid pipe aligned with memory register and product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg  <= '0;
            last_reg <= '0;
        end else begin
            vld_reg  <= {vld_reg[0], state_reg == ISSUE};
            last_reg <= {last_reg[0], (state_reg == ISSUE) && last_addr};
        end
    end

    neuron_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .BIAS   (BIAS)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .load_bias (accept),
        .acc_en    (vld_reg[1]),
        .weight    (rom_dout),
        .sample    (x_data),
        .sum       (mac_sum)
    );

    // The result captures the running sum plus the final product on the same
    // edge that would accumulate it, so done can follow one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out_reg <= '0;
            fire_reg    <= 1'b0;
        end else if (last_reg[1]) begin
            acc_out_reg <= mac_sum;
            fire_reg    <= $signed(mac_sum) >= $signed(ACC_W'(THRESH));
        end
    end

    assign acc_out = acc_out_reg;
    assign fire    = fire_reg;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
module tb_neuron_mac_sequencer;

    localparam int N    = 10;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int ACCW = 40;
    localparam int NI   = 3;   // 0: BIAS 0 / THRESH 0, 1: BIAS -30 / THRESH 0, 2: BIAS -30 / THRESH -7

    logic clk;
    logic rst;
    logic start;

    logic            busy_w     [NI];
    logic            done_w     [NI];
    logic            fire_w     [NI];
    logic [AW-1:0]   rom_addr_w [NI];
    logic [AW-1:0]   x_addr_w   [NI];
    logic [DW-1:0]   rom_dout_w [NI];
    logic [DW-1:0]   x_data_w   [NI];
    logic [ACCW-1:0] acc_w      [NI];

    logic [DW-1:0] rom_mem [16];
    logic [DW-1:0] x_mem   [16];

    longint prev_acc  [NI];
    longint prev_fire [NI];

    int errors = 0;
    int checks = 0;
    int run_id = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int B = (gi == 0) ? 0 : -30;
            localparam int T = (gi == 2) ? -7 : 0;
            neuron_mac_sequencer #(
                .N_INPUTS (N),
                .DATA_W   (DW),
                .ADDR_W   (AW),
                .ACC_W    (ACCW),
                .BIAS     (B),
                .THRESH   (T)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .start    (start),
                .busy     (busy_w[gi]),
                .done     (done_w[gi]),
                .rom_addr (rom_addr_w[gi]),
                .rom_dout (rom_dout_w[gi]),
                .x_addr   (x_addr_w[gi]),
                .x_data   (x_data_w[gi]),
                .acc_out  (acc_w[gi]),
                .fire     (fire_w[gi])
            );
        end
    endgenerate

    // Registered-read memory models, one read port per DUT instance.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            rom_dout_w[i] <= rom_mem[rom_addr_w[i][3:0]];
            x_data_w[i]   <= x_mem[x_addr_w[i][3:0]];
        end
    end

    function automatic longint sx16(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx40(input logic [ACCW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint bias_of(input int i);
        return (i == 0) ? 0 : -30;
    endfunction

    function automatic longint thresh_of(input int i);
        return (i == 2) ? -7 : 0;
    endfunction

    // Reference: bias + sum over k=1..N of weight[k] * x[k-1].
    function automatic longint model_acc(input int i);
        longint s;
        s = bias_of(i);
        for (int k = 1; k <= N; k++) begin
            s = s + sx16(rom_mem[k]) * sx16(x_mem[k-1]);
        end
        return s;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_default_rom();
        logic [DW-1:0] w [16];
        w = '{16'd100, 16'd0, 16'd0, 16'd4, 16'd5, 16'd6, 16'd8, 16'd0,
              16'd0, 16'd0, 16'd0, 16'h1234, 16'h0042, 16'hFFF0, 16'd7, 16'd9};
        for (int k = 0; k < 16; k++) rom_mem[k] = w[k];
    endtask

    // mode 0: all +1, 1: ramp x[i]=i+1, 2: all -1, 3: random
    task automatic set_x(input int mode);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0:       x_mem[k] = 16'd1;
                1:       x_mem[k] = DW'(k + 1);
                2:       x_mem[k] = 16'hFFFF;
                default: x_mem[k] = DW'($urandom);
            endcase
        end
        x_mem[N] = 16'h0777;   // never indexed; poisons a stray read
    endtask

    // Runs one evaluation and checks the cycle-by-cycle protocol.
    // immediate: raise start at the current negedge instead of the next one.
    // hold: keep start high throughout; otherwise pulse it again at pulse_at.
    task automatic run_eval(input bit immediate, input bit hold, input int pulse_at);
        longint exp_acc  [NI];
        longint exp_fire [NI];
        int     bad      [NI];
        int     n_done   [NI];
        longint e_acc;
        longint e_fire;
        for (int i = 0; i < NI; i++) begin
            exp_acc[i]  = model_acc(i);
            exp_fire[i] = (exp_acc[i] >= thresh_of(i)) ? 1 : 0;
            bad[i]      = 0;
            n_done[i]   = 0;
        end
        if (!immediate) @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            if (hold) start = (c < N + 3);
            else      start = (c == pulse_at);
            for (int i = 0; i < NI; i++) begin
                e_acc  = (c < N + 3) ? prev_acc[i]  : exp_acc[i];
                e_fire = (c < N + 3) ? prev_fire[i] : exp_fire[i];
                if (done_w[i]) n_done[i]++;
                if (busy_w[i] !== (c <= N + 2))                          bad[i]++;
                if (done_w[i] !== (c == N + 3))                          bad[i]++;
                if (rom_addr_w[i] !== ((c <= N) ? AW'(c) : AW'(0)))      bad[i]++;
                if (x_addr_w[i] !== ((c <= N) ? AW'(c - 1) : AW'(0)))    bad[i]++;
                if (sx40(acc_w[i]) !== e_acc)                            bad[i]++;
                if (longint'(fire_w[i]) !== e_fire)                      bad[i]++;
            end
        end
        start = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("timing[%0d] bad cycles", i), bad[i], 0);
            check($sformatf("done_count[%0d]", i), n_done[i], 1);
            check($sformatf("acc_out[%0d]", i), sx40(acc_w[i]), exp_acc[i]);
            check($sformatf("fire[%0d]", i), longint'(fire_w[i]), exp_fire[i]);
            prev_acc[i]  = exp_acc[i];
            prev_fire[i] = exp_fire[i];
        end
        $display("run %0d: acc_out=%0d/%0d/%0d fire=%0d/%0d/%0d", run_id,
                 sx40(acc_w[0]), sx40(acc_w[1]), sx40(acc_w[2]),
                 fire_w[0], fire_w[1], fire_w[2]);
        run_id++;
        // The cycle after done must be idle with no second pulse.
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("post_done_idle[%0d]", i),
                  longint'({busy_w[i], done_w[i]}), 0);
        end
    endtask

    typedef struct {
        int     mode;
        longint acc0, acc1, acc2;
        longint fire0, fire1, fire2;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int bad;
        vecs[0] = '{mode: 0, acc0: 23,  acc1: -7,  acc2: -7,  fire0: 1, fire1: 0, fire2: 1};
        vecs[1] = '{mode: 1, acc0: 110, acc1: 80,  acc2: 80,  fire0: 1, fire1: 1, fire2: 1};
        vecs[2] = '{mode: 2, acc0: -23, acc1: -53, acc2: -53, fire0: 0, fire1: 0, fire2: 0};

        rst   = 1'b1;
        start = 1'b0;
        load_default_rom();
        set_x(0);
        for (int i = 0; i < NI; i++) begin
            prev_acc[i]  = 0;
            prev_fire[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_state[%0d]", i),
                  longint'({busy_w[i], done_w[i], fire_w[i]}) + sx40(acc_w[i])
                  + longint'(rom_addr_w[i]) + longint'(x_addr_w[i]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Table-driven default-weight runs
        for (int v = 0; v < 3; v++) begin
            set_x(vecs[v].mode);
            run_eval(1'b0, 1'b0, 0);
            check($sformatf("table%0d acc0", v), sx40(acc_w[0]), vecs[v].acc0);
            check($sformatf("table%0d acc1", v), sx40(acc_w[1]), vecs[v].acc1);
            check($sformatf("table%0d acc2", v), sx40(acc_w[2]), vecs[v].acc2);
            check($sformatf("table%0d fire0", v), longint'(fire_w[0]), vecs[v].fire0);
            check($sformatf("table%0d fire1", v), longint'(fire_w[1]), vecs[v].fire1);
            check($sformatf("table%0d fire2", v), longint'(fire_w[2]), vecs[v].fire2);
        end

        // start held high through the run, then start re-pulsed mid-run
        set_x(1);
        run_eval(1'b0, 1'b1, 0);
        set_x(0);
        run_eval(1'b0, 1'b0, 5);

        // Back-to-back: second start in the idle cycle right after done
        set_x(2);
        run_eval(1'b0, 1'b0, 0);
        set_x(1);
        run_eval(1'b1, 1'b0, 0);

        // Reset in the middle of a run
        set_x(3);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int i = 0; i < NI; i++) begin
                if ({busy_w[i], done_w[i], fire_w[i]} !== 3'b000) bad++;
                if (acc_w[i] !== '0 || rom_addr_w[i] !== '0 || x_addr_w[i] !== '0) bad++;
            end
            @(negedge clk);
        end
        check("reset_mid_run outputs nonzero", bad, 0);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            prev_acc[i]  = 0;
            prev_fire[i] = 0;
        end
        bad = 0;
        repeat (16) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (done_w[i] || busy_w[i]) bad++;
        end
        check("reset_mid_run stray activity", bad, 0);
        set_x(0);
        run_eval(1'b0, 1'b0, 0);

        // Randomized weights and inputs against the reference model
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 16; k++) rom_mem[k] = DW'($urandom);
            set_x(3);
            run_eval(1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 14));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
